// File: rtl/apb_pkg.sv
// Shared definitions for the APB round-robin requester: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: search starts at i_ptr and wraps modulo NUM_REQ;
// the first requesting index wins and is returned as one-hot, index and valid.
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [PTR_W-1:0]   o_idx_c,
  output logic               o_valid_c
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] w_idx;

  // One extra bit keeps ptr+k from overflowing before the modulo wrap.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = SUM_W'(i_ptr) + SUM_W'(k);
      if (w_idx >= SUM_W'(NUM_REQ)) begin
        w_idx = w_idx - SUM_W'(NUM_REQ);
      end
      if (!o_valid_c && i_req[w_idx[PTR_W-1:0]]) begin
        o_valid_c                   = 1'b1;
        o_idx_c                     = w_idx[PTR_W-1:0];
        o_grant_c[w_idx[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_requester.sv
// Round-robin arbiter plus APB requester FSM sharing one APB completer among NUM_REQ requesters.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_requester
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pslverr
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("apb_rr_requester: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  apb_state_e          r_state,    w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr,   w_rr_ptr_nxt;
  logic [NUM_REQ-1:0]  r_owner_oh, w_owner_nxt;
  logic                r_psel,     w_psel_nxt;
  logic                r_penable,  w_penable_nxt;
  logic                r_pwrite,   w_pwrite_nxt;
  logic [ADDR_W-1:0]   r_paddr,    w_paddr_nxt;
  logic [DATA_W-1:0]   r_pwdata,   w_pwdata_nxt;
  logic [NUM_REQ-1:0]  r_done,     w_done_nxt;
  logic [DATA_W-1:0]   r_rdata,    w_rdata_nxt;
  logic                r_err,      w_err_nxt;

  logic [NUM_REQ-1:0]  w_arb_req;
  logic [NUM_REQ-1:0]  w_arb_grant;
  logic [PTR_W-1:0]    w_arb_idx;
  logic                w_arb_valid;
  logic                w_launch;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // The finishing requester is ignored on its completing cycle and while its done is showing.
  assign w_arb_req = req & ~(r_done | ((r_state == ACCESS) ? r_owner_oh : '0));

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req     (w_arb_req),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_arb_grant),
    .o_idx_c   (w_arb_idx),
    .o_valid_c (w_arb_valid)
  );

  // Request fields of the current winner.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_arb_grant[i]) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             w_timeout;

  // Counts ACCESS cycles of the current transfer; cleared on every SETUP.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_to_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_to_cnt <= '0;
    end else if (r_state == ACCESS) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == ACCESS) && !pready && (r_to_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_owner_nxt   = r_owner_oh;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_done_nxt    = '0;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;
    w_launch      = 1'b0;

    case (r_state)
      IDLE: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_launch      = w_arb_valid;
      end
      SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          w_done_nxt    = r_owner_oh;
          w_rdata_nxt   = r_pwrite ? '0 : prdata;
          w_err_nxt     = pslverr;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_state_nxt   = IDLE;
          w_launch      = w_arb_valid;
        end
`ifdef APB_TIMEOUT_EN
        else if (w_timeout) begin
          w_done_nxt    = r_owner_oh;
          w_rdata_nxt   = '0;
          w_err_nxt     = 1'b1;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
`endif
      end
      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase

    // Grant: latch the winner's fields and start SETUP (back-to-back when coming from ACCESS).
    if (w_launch) begin
      w_state_nxt   = SETUP;
      w_psel_nxt    = 1'b1;
      w_penable_nxt = 1'b0;
      w_pwrite_nxt  = w_sel_write;
      w_paddr_nxt   = w_sel_addr;
      w_pwdata_nxt  = w_sel_wdata;
      w_owner_nxt   = w_arb_grant;
      w_rr_ptr_nxt  = (w_arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rr_ptr   <= '0;
      r_owner_oh <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner_oh <= w_owner_nxt;
      r_psel     <= w_psel_nxt;
      r_penable  <= w_penable_nxt;
      r_pwrite   <= w_pwrite_nxt;
      r_paddr    <= w_paddr_nxt;
      r_pwdata   <= w_pwdata_nxt;
      r_done     <= w_done_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign done      = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;

endmodule
